// File: rtl/chan_scan_mux_pkg.sv
// Shared definitions for the channel scan multiplexer and its scan counter.
package chan_scan_mux_pkg;

  // Select-source encoding: direct channel select or internal round-robin scan.
  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_e;

  // Counter width able to hold 0..depth-1, but never narrower than one bit,
  // so a dwell of one cycle still gets a legal (constant-zero) register.
  function automatic int cnt_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/chan_scan_mux_if.sv
// Channel data, select controls and registered results of the scan multiplexer.
interface chan_scan_mux_if
  import chan_scan_mux_pkg::*;
#(
  parameter  int W    = 4,
  parameter  int N    = 8,
  localparam int SELW = $clog2(N)
) ();

  logic [N*W-1:0]  data;     // channel k at data[k*W +: W]
  mode_e           mode;
  logic [SELW-1:0] sel_in;
  logic            hold;
  logic [W-1:0]    y;
  logic [SELW-1:0] sel_out;
  logic            wrap;
  logic            sel_err;

  // Producer side: owns the channel data and select controls.
  modport master (
    output data, mode, sel_in, hold,
    input  y, sel_out, wrap, sel_err
  );

  // Multiplexer side.
  modport slave (
    input  data, mode, sel_in, hold,
    output y, sel_out, wrap, sel_err
  );

endinterface

// File: rtl/scan_counter.sv
// Mod-N channel counter with a dwell prescaler, freeze input and wrap pulse.
// While not running it parks with the prescaler cleared, optionally loading a
// channel, so a later run starts with a full dwell on that channel.
module scan_counter
  import chan_scan_mux_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int DWELL = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            hold,
  input  logic            load,
  input  logic [SELW-1:0] load_val,
  output logic [SELW-1:0] chan,
  output logic            wrap
);

  localparam int              CNTW       = cnt_width(DWELL);
  localparam logic [CNTW-1:0] DWELL_LAST = CNTW'(DWELL - 1);
  localparam logic [SELW-1:0] CHAN_LAST  = SELW'(N - 1);

  logic [CNTW-1:0] dwell_cnt;
  logic            dwell_done;
  logic            last_chan;

  assign dwell_done = (dwell_cnt == DWELL_LAST);
  assign last_chan  = (chan == CHAN_LAST);

  // Channel/prescaler update; wrap is raised on the edge that steps N-1 -> 0.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      chan      <= '0;
      dwell_cnt <= '0;
      wrap      <= 1'b0;
    end else if (!run) begin
      dwell_cnt <= '0;
      wrap      <= 1'b0;
      if (load) chan <= load_val;
    end else if (hold) begin
      wrap <= 1'b0;
    end else if (dwell_done) begin
      dwell_cnt <= '0;
      chan      <= last_chan ? '0 : chan + SELW'(1);
      wrap      <= last_chan;
    end else begin
      dwell_cnt <= dwell_cnt + CNTW'(1);
      wrap      <= 1'b0;
    end
  end

endmodule

// File: rtl/chan_scan_mux.sv
// Registered N-to-1 channel selector: direct select (manual) or round-robin
// scan with a programmable dwell per channel (auto). W and N must match the
// parameters of the connected interface instance.
module chan_scan_mux
  import chan_scan_mux_pkg::*;
#(
  parameter  int W     = 4,
  parameter  int N     = 8,
  parameter  int DWELL = 4,
  localparam int SELW  = $clog2(N)
) (
  input logic           clk,
  input logic           rst,
  chan_scan_mux_if.slave bus
);

  logic [SELW-1:0] chan;
  logic            scan_wrap;
  logic            auto_mode;
  logic            sel_valid;
  logic [SELW-1:0] pick;
  logic [W-1:0]    picked;

  logic [W-1:0]    y_q;
  logic [SELW-1:0] sel_q;
  logic            err_q;

  assign auto_mode = (bus.mode == MODE_AUTO);
  // N need not be a power of two, so some sel_in codes name no channel.
  assign sel_valid = (32'(bus.sel_in) < 32'(N));

  // In manual mode the scanner follows valid selects, so switching to auto
  // continues the scan from the channel currently shown.
  scan_counter #(
    .N     (N),
    .DWELL (DWELL)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .run      (auto_mode),
    .hold     (bus.hold),
    .load     (sel_valid),
    .load_val (bus.sel_in),
    .chan     (chan),
    .wrap     (scan_wrap)
  );

  // Choose the channel index for this cycle and extract its data.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave it unassigned and infer a latch.
    pick   = chan;
    picked = '0;
    if (!auto_mode) pick = bus.sel_in;
    picked = bus.data[int'(pick) * W +: W];
  end

  // Output registers; an invalid manual select keeps the last valid channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q   <= '0;
      sel_q <= '0;
      err_q <= 1'b0;
    end else if (auto_mode) begin
      y_q   <= picked;
      sel_q <= chan;
      err_q <= 1'b0;
    end else if (sel_valid) begin
      y_q   <= picked;
      sel_q <= bus.sel_in;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b1;
    end
  end

  assign bus.y       = y_q;
  assign bus.sel_out = sel_q;
  assign bus.sel_err = err_q;
  assign bus.wrap    = scan_wrap;

endmodule

// File: tb/tb_chan_scan_mux.sv
// Directed bench for chan_scan_mux: reset, manual select, out-of-range select,
// auto scan timing/wrap, hold, mode switching and mid-scan reset.
module tb_chan_scan_mux;
  import chan_scan_mux_pkg::*;

  logic clk;
  logic rst_a;
  logic rst_b;
  logic rst_c;

  int n_checks = 0;
  int n_fail   = 0;

  chan_scan_mux_if #(.W(4), .N(8)) bus_a ();
  chan_scan_mux_if #(.W(4), .N(6)) bus_b ();
  chan_scan_mux_if #(.W(4), .N(5)) bus_c ();
  chan_scan_mux_if #(.W(4), .N(2)) bus_d ();

  chan_scan_mux #(.W(4), .N(8), .DWELL(3)) u_a (.clk(clk), .rst(rst_a), .bus(bus_a.slave));
  chan_scan_mux #(.W(4), .N(6), .DWELL(3)) u_b (.clk(clk), .rst(rst_b), .bus(bus_b.slave));
  chan_scan_mux #(.W(4), .N(5), .DWELL(3)) u_c (.clk(clk), .rst(rst_c), .bus(bus_c.slave));
  chan_scan_mux #(.W(4), .N(2), .DWELL(1)) u_d (.clk(clk), .rst(rst_c), .bus(bus_d.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed 4-bit channels, channel k holding base+k.
  function automatic logic [31:0] ramp(input int n, input int base);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v[k*4 +: 4] = 4'(base + k);
    return v;
  endfunction

  initial begin
    int wraps_c;
    int wraps_d;
    int exp_sel;

    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;
    bus_a.data = ramp(8, 3);
    bus_b.data = 24'(ramp(6, 3));
    bus_c.data = 20'(ramp(5, 1));
    bus_d.data = 8'h3C;           // ch0 = C, ch1 = 3
    bus_a.mode = MODE_AUTO;
    bus_b.mode = MODE_MANUAL;
    bus_c.mode = MODE_AUTO;
    bus_d.mode = MODE_AUTO;
    bus_a.sel_in = '0;
    bus_b.sel_in = '0;
    bus_c.sel_in = '0;
    bus_d.sel_in = '0;
    bus_a.hold = 1'b0;
    bus_b.hold = 1'b0;
    bus_c.hold = 1'b0;
    bus_d.hold = 1'b0;

    // Reset held for two edges in auto mode with nonzero data.
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("rst_y_%0d", i), 32'(bus_a.y), 32'd0);
      check($sformatf("rst_sel_%0d", i), 32'(bus_a.sel_out), 32'd0);
      check($sformatf("rst_wrap_%0d", i), 32'(bus_a.wrap), 32'd0);
      check($sformatf("rst_err_%0d", i), 32'(bus_a.sel_err), 32'd0);
    end
    rst_a = 1'b0;
    tick();
    check("post_rst_y", 32'(bus_a.y), 32'd3);
    check("post_rst_sel", 32'(bus_a.sel_out), 32'd0);

    // Manual select sweep: channel k carries k+3.
    bus_a.mode = MODE_MANUAL;
    for (int s = 0; s < 8; s++) begin
      bus_a.sel_in = 3'(s);
      tick();
      check($sformatf("man_y_%0d", s), 32'(bus_a.y), 32'(s + 3));
      check($sformatf("man_sel_%0d", s), 32'(bus_a.sel_out), 32'(s));
      check($sformatf("man_err_%0d", s), 32'(bus_a.sel_err), 32'd0);
    end

    // Park on channel 2, go auto for one edge (dwell count 1), then hold.
    bus_a.sel_in = 3'd2;
    tick();
    bus_a.mode = MODE_AUTO;
    tick();
    check("auto_start_sel", 32'(bus_a.sel_out), 32'd2);
    bus_a.hold = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("hold_sel_%0d", i), 32'(bus_a.sel_out), 32'd2);
      check($sformatf("hold_y_%0d", i), 32'(bus_a.y), (i >= 3) ? 32'hA : 32'h5);
      check($sformatf("hold_wrap_%0d", i), 32'(bus_a.wrap), 32'd0);
      if (i == 2) bus_a.data[11:8] = 4'hA;
    end
    // Two remaining dwell cycles on channel 2, then channel 3 shows.
    bus_a.hold = 1'b0;
    tick();
    check("rel_sel_1", 32'(bus_a.sel_out), 32'd2);
    check("rel_y_1", 32'(bus_a.y), 32'hA);
    tick();
    check("rel_sel_2", 32'(bus_a.sel_out), 32'd2);
    bus_a.data[11:8] = 4'h5;
    tick();
    check("rel_sel_3", 32'(bus_a.sel_out), 32'd3);
    check("rel_y_3", 32'(bus_a.y), 32'd6);

    // Auto at channel 3 -> manual channel 6 -> auto again.
    bus_a.mode   = MODE_MANUAL;
    bus_a.sel_in = 3'd6;
    tick();
    check("sw_man_sel", 32'(bus_a.sel_out), 32'd6);
    check("sw_man_y", 32'(bus_a.y), 32'd9);
    bus_a.mode = MODE_AUTO;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_sel = (i < 3) ? 6 : 7;
      check($sformatf("sw_auto_sel_%0d", i), 32'(bus_a.sel_out), 32'(exp_sel));
      check($sformatf("sw_auto_y_%0d", i), 32'(bus_a.y), 32'(exp_sel + 3));
    end

    // Reset at dwell count 1 on channel 7: scan restarts on 0 with a full dwell.
    rst_a = 1'b1;
    tick();
    check("mid_rst_y", 32'(bus_a.y), 32'd0);
    check("mid_rst_sel", 32'(bus_a.sel_out), 32'd0);
    check("mid_rst_wrap", 32'(bus_a.wrap), 32'd0);
    rst_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rst_scan_sel_%0d", i), 32'(bus_a.sel_out), (i < 3) ? 32'd0 : 32'd1);
      check($sformatf("rst_scan_wrap_%0d", i), 32'(bus_a.wrap), 32'd0);
    end

    // Out-of-range manual select with N=6.
    rst_b = 1'b0;
    bus_b.sel_in = 3'd4;
    tick();
    check("b_sel4_y", 32'(bus_b.y), 32'd7);
    check("b_sel4_err", 32'(bus_b.sel_err), 32'd0);
    bus_b.sel_in = 3'd6;
    tick();
    check("b_sel6_err", 32'(bus_b.sel_err), 32'd1);
    check("b_sel6_y", 32'(bus_b.y), 32'd7);
    check("b_sel6_sel", 32'(bus_b.sel_out), 32'd4);
    bus_b.sel_in = 3'd7;
    tick();
    check("b_sel7_err", 32'(bus_b.sel_err), 32'd1);
    check("b_sel7_sel", 32'(bus_b.sel_out), 32'd4);
    bus_b.sel_in = 3'd5;
    tick();
    check("b_sel5_err", 32'(bus_b.sel_err), 32'd0);
    check("b_sel5_y", 32'(bus_b.y), 32'd8);
    check("b_sel5_sel", 32'(bus_b.sel_out), 32'd5);

    // Free-running scans: N=5/DWELL=3 (period 15) and N=2/DWELL=1 (period 2).
    rst_c   = 1'b0;
    wraps_c = 0;
    wraps_d = 0;
    for (int t = 0; t < 32; t++) begin
      tick();
      exp_sel = (t / 3) % 5;
      check($sformatf("c_sel_%0d", t), 32'(bus_c.sel_out), 32'(exp_sel));
      check($sformatf("c_y_%0d", t), 32'(bus_c.y), 32'(exp_sel + 1));
      check($sformatf("c_wrap_%0d", t), 32'(bus_c.wrap), (t % 15 == 14) ? 32'd1 : 32'd0);
      check($sformatf("d_sel_%0d", t), 32'(bus_d.sel_out), 32'(t % 2));
      check($sformatf("d_y_%0d", t), 32'(bus_d.y), (t % 2 == 0) ? 32'hC : 32'h3);
      check($sformatf("d_wrap_%0d", t), 32'(bus_d.wrap), 32'(t % 2));
      if (bus_c.wrap === 1'b1) wraps_c++;
      if (bus_d.wrap === 1'b1) wraps_d++;
    end
    check("c_wrap_count", 32'(wraps_c), 32'd2);
    check("d_wrap_count", 32'(wraps_d), 32'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
